// File: rtl/trap_sequencer.sv
// trap_sequencer: privilege-phase tracker and trap entry/return sequencer.
// Takes the per-stage exception codes and produces the boot and trap
// permissions. It latches cause/EPC/TVAL, kills the faulting E instruction,
// and issues flush plus fetch-redirect pulses on trap entry and on mret.
//
// Handshake: none. Every input is sampled on each rising clk edge. The
// flush/redirect outputs are single-cycle registered pulses that the
// pipeline must act on in the cycle they are high. o_kill_e is
// combinational and only qualifies the E instruction in the current cycle.
module trap_sequencer #(
  parameter logic [31:0] TRAP_VEC_BASE = 32'h0000_0000,
  parameter logic [2:0]  TEXT_REGION   = 3'b010,
  parameter logic        ECALL_SKIP    = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [3:0]  i_exception_code_f,
  input  logic [3:0]  i_exception_code_e,
  input  logic [31:0] i_pc_f,
  input  logic [31:0] i_pc_e,
  input  logic [31:0] i_alu_out_e,
  input  logic        i_pc_src_e,
  input  logic        i_mret_e,
  input  logic        i_stall_f,
  output logic        o_reset_permission,
  output logic        o_trap_permission,
  output logic        o_kill_e,
  output logic        o_flush_fde,
  output logic        o_redirect_valid,
  output logic [31:0] o_redirect_pc,
  output logic [3:0]  o_mcause,
  output logic [31:0] o_mepc,
  output logic [31:0] o_mtval,
  output logic        o_halted,
  output logic [2:0]  o_state
);

  // Exception code encoding shared with the core's Constants.vh.
  localparam logic [3:0] NO_E                    = 4'h0;
  localparam logic [3:0] E_FETCH_ADDR_MISALIGNED = 4'h1;
  localparam logic [3:0] E_FETCH_ACCESS_FAULT    = 4'h2;
  localparam logic [3:0] E_ILLEGAL_INSTR         = 4'h3;
  localparam logic [3:0] E_ECALL                 = 4'h4;
  localparam logic [3:0] E_LOAD_ADDR_MISALIGNED  = 4'h5;
  localparam logic [3:0] E_LOAD_ACCESS_FAULT     = 4'h6;
  localparam logic [3:0] E_STORE_ADDR_MISALIGNED = 4'h7;
  localparam logic [3:0] E_STORE_ACCESS_FAULT    = 4'h8;
  localparam logic [3:0] E_SP_OUT_OF_RANGE       = 4'h9;

  typedef enum logic [2:0] {
    ST_BOOT   = 3'd0,
    ST_RUN    = 3'd1,
    ST_ENTER  = 3'd2,
    ST_TRAP   = 3'd3,
    ST_RETURN = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic        latch_en;
  logic        kill;
  logic        exc_e, exc_f, exc_any;
  logic [3:0]  sel_code;
  logic [31:0] sel_pc;
  logic [31:0] sel_tval;
  logic [3:0]  mcause_q;
  logic [31:0] mepc_q, mtval_q;
  logic [31:0] ret_pc;

  // Exception source selection: E has priority. An F fault only counts when
  // the fetched instruction is on the correct path and actually advancing.
  always_comb begin
    exc_e   = (i_exception_code_e != NO_E);
    exc_f   = (i_exception_code_f != NO_E) && !i_pc_src_e && !i_stall_f;
    exc_any = exc_e || exc_f;
    sel_code = exc_e ? i_exception_code_e : i_exception_code_f;
    sel_pc   = exc_e ? i_pc_e : i_pc_f;
    case (sel_code)
      E_LOAD_ADDR_MISALIGNED,
      E_LOAD_ACCESS_FAULT,
      E_STORE_ADDR_MISALIGNED,
      E_STORE_ACCESS_FAULT,
      E_SP_OUT_OF_RANGE:       sel_tval = i_alu_out_e;
      E_FETCH_ADDR_MISALIGNED: sel_tval = i_pc_f;
      default:                 sel_tval = 32'h0;
    endcase
  end

  // Next-state logic. A fault while already servicing a trap (or still
  // booting) is unrecoverable, so it freezes the core instead of nesting.
  always_comb begin
    state_d  = state_q;
    latch_en = 1'b0;
    kill     = 1'b0;
    case (state_q)
      ST_BOOT: begin
        if (exc_any) begin
          state_d = ST_HALT;
          kill    = exc_e;
        end else if (!i_stall_f && (i_pc_f[20:18] == TEXT_REGION)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (exc_any) begin
          state_d  = ST_ENTER;
          latch_en = 1'b1;
          kill     = exc_e;
        end
      end
      // Everything in flight during ENTER/RETURN is being flushed.
      ST_ENTER:  state_d = ST_TRAP;
      ST_TRAP: begin
        if (exc_any) begin
          state_d = ST_HALT;
          kill    = exc_e;
        end else if (i_mret_e) begin
          state_d = ST_RETURN;
        end
      end
      ST_RETURN: state_d = ST_RUN;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_BOOT;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= ST_BOOT;
    else          state_q <= state_d;
  end

  // Trap CSRs: captured only on the first trap, held across a double fault.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      mcause_q <= NO_E;
      mepc_q   <= 32'h0;
      mtval_q  <= 32'h0;
    end else if (latch_en) begin
      mcause_q <= sel_code;
      mepc_q   <= sel_pc;
      mtval_q  <= sel_tval;
    end
  end

  // Return target: ECALL resumes after the call instruction (wraps mod 2^32).
  always_comb begin
    ret_pc = mepc_q;
    if (ECALL_SKIP && (mcause_q == E_ECALL)) ret_pc = mepc_q + 32'd4;
  end

  // Output decode from the registered state; pulses last exactly one cycle
  // because ENTER and RETURN are single-cycle states.
  always_comb begin
    o_reset_permission = (state_q == ST_BOOT);
    o_trap_permission  = (state_q == ST_ENTER) || (state_q == ST_TRAP);
    o_flush_fde        = (state_q == ST_ENTER) || (state_q == ST_RETURN);
    o_redirect_valid   = (state_q == ST_ENTER) || (state_q == ST_RETURN);
    o_halted           = (state_q == ST_HALT);
    o_redirect_pc      = 32'h0;
    if (state_q == ST_ENTER)  o_redirect_pc = TRAP_VEC_BASE;
    if (state_q == ST_RETURN) o_redirect_pc = ret_pc;
    o_kill_e = kill;
    o_mcause = mcause_q;
    o_mepc   = mepc_q;
    o_mtval  = mtval_q;
    o_state  = state_q;
  end

endmodule
